// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI master arbiter.
// Holds the arbiter state encoding and the grant/ID width function.
// Used by spi_master_arbiter and spi_arb_id_fifo.
package spi_arb_pkg;

  // Arbiter states: IDLE searches for a winner, BURST locks onto it.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_arb_id_fifo.sv
// Small FIFO of requester IDs awaiting an SPI response.
// Latency: a pushed entry is visible at pop_dat the cycle after the push.
// Backpressure: push ignored while full, pop ignored while empty.
module spi_arb_id_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  // Explicit wrap keeps non-power-of-two depths safe as well.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_dat = mem[rd_ptr];

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin burst arbiter sharing one SPI master; routes responses back in order.
// Latency: grant one cycle after request seen, words then pass combinationally; responses pass combinationally.
// Backpressure: spi_rdy/out_rdy propagate straight through; stalls when ID FIFO full. Watchdog under SPI_ARB_TIMEOUT_EN.
module spi_master_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int IDQ  = 4
`ifdef SPI_ARB_TIMEOUT_EN
  ,
  parameter int TMO  = 64
`endif
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NREQ-1:0]               req_val,
  input  logic [NREQ-1:0]               req_last,
  input  logic [NREQ*DW-1:0]            req_msg,
  output logic [NREQ-1:0]               req_rdy,
  output logic                          spi_val,
  input  logic                          spi_rdy,
  output logic [DW-1:0]                 spi_msg,
  input  logic                          rsp_val,
  output logic                          rsp_rdy,
  input  logic [DW-1:0]                 rsp_msg,
  output logic [NREQ-1:0]               out_val,
  input  logic [NREQ-1:0]               out_rdy,
  output logic [DW-1:0]                 out_msg,
  output logic [id_width(NREQ)-1:0]     grant_id
`ifdef SPI_ARB_TIMEOUT_EN
  ,
  output logic                          timeout_err
`endif
);

  localparam int GW = id_width(NREQ);
  typedef logic [GW-1:0] gid_t;

  arb_state_t state_q, state_d;
  gid_t       ptr_q, ptr_d;
  gid_t       gnt_q, gnt_d;

  logic       push;
  logic       pop;
  logic       idq_full;
  logic       idq_empty;
  gid_t       idq_head;

  logic [DW-1:0] req_word [NREQ];

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = (TMO > 2) ? $clog2(TMO) : 1;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_fire;
  logic          tmo_err_q;
`endif

  for (genvar i = 0; i < NREQ; i++) begin : g_word
    assign req_word[i] = req_msg[i*DW +: DW];
  end

  // First valid requester strictly after p, wrapping modulo NREQ.
  function automatic gid_t rr_pick(input logic [NREQ-1:0] v, input gid_t p);
    gid_t w;
    gid_t c;
    logic f;
    w = '0;
    f = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      c = gid_t'((int'(p) + i) % NREQ);
      if (!f && v[c]) begin
        f = 1'b1;
        w = c;
      end
    end
    return w;
  endfunction

  assign spi_msg  = req_word[gnt_q];
  assign grant_id = gnt_q;
  assign out_msg  = rsp_msg;

  // Grant FSM: pick a winner in IDLE, pass only that requester during BURST.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    spi_val = 1'b0;
    req_rdy = '0;
    push    = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    tmo_fire  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef SPI_ARB_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
        if (|req_val) begin
          gnt_d   = rr_pick(req_val, ptr_q);
          state_d = BURST;
        end
      end
      BURST: begin
        spi_val        = req_val[gnt_q] & ~idq_full;
        req_rdy[gnt_q] = spi_rdy & ~idq_full;
        push           = spi_val & spi_rdy;
        if (push && req_last[gnt_q]) begin
          ptr_d   = gnt_q;
          state_d = IDLE;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        // Idle cycles of the granted requester count towards the watchdog.
        if (push) begin
          tmo_cnt_d = '0;
        end else if (!req_val[gnt_q]) begin
          if (tmo_cnt_q == TW'(TMO - 1)) begin
            tmo_cnt_d = '0;
            tmo_fire  = 1'b1;
            ptr_d     = gnt_q;
            state_d   = IDLE;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
          end
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Arbiter state; ptr starts at NREQ-1 so requester 0 wins first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= gid_t'(NREQ - 1);
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  assign timeout_err = tmo_err_q;

  // Watchdog counter and sticky error flag; only reset clears the flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      if (tmo_fire) begin
        tmo_err_q <= 1'b1;
      end
    end
  end
`endif

  // Response steering: the oldest outstanding ID owns the response channel.
  always_comb begin
    out_val = '0;
    rsp_rdy = 1'b0;
    if (!idq_empty) begin
      out_val[idq_head] = rsp_val;
      rsp_rdy           = out_rdy[idq_head];
    end
  end

  assign pop = rsp_val & rsp_rdy;

  spi_arb_id_fifo #(
    .W     (GW),
    .DEPTH (IDQ)
  ) u_id_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (gnt_q),
    .pop      (pop),
    .pop_dat  (idq_head),
    .full     (idq_full),
    .empty    (idq_empty)
  );

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter (NREQ=3, DW=32, IDQ=4).
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
// Watchdog steps are built only when SPI_ARB_TIMEOUT_EN is defined (TMO=8).
module tb_spi_master_arbiter;

  logic        clk;
  logic        reset;
  logic [2:0]  req_val;
  logic [2:0]  req_last;
  logic [95:0] req_msg;
  logic [2:0]  req_rdy;
  logic        spi_val;
  logic        spi_rdy;
  logic [31:0] spi_msg;
  logic        rsp_val;
  logic        rsp_rdy;
  logic [31:0] rsp_msg;
  logic [2:0]  out_val;
  logic [2:0]  out_rdy;
  logic [31:0] out_msg;
  logic [1:0]  grant_id;
`ifdef SPI_ARB_TIMEOUT_EN
  logic        timeout_err;
`endif

  int errors;
  int checks;
  int hs1;

  spi_master_arbiter #(
    .NREQ (3),
    .DW   (32),
    .IDQ  (4)
`ifdef SPI_ARB_TIMEOUT_EN
    ,
    .TMO  (8)
`endif
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_val  (req_val),
    .req_last (req_last),
    .req_msg  (req_msg),
    .req_rdy  (req_rdy),
    .spi_val  (spi_val),
    .spi_rdy  (spi_rdy),
    .spi_msg  (spi_msg),
    .rsp_val  (rsp_val),
    .rsp_rdy  (rsp_rdy),
    .rsp_msg  (rsp_msg),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_msg  (out_msg),
    .grant_id (grant_id)
`ifdef SPI_ARB_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    hs1      = 0;
    reset    = 1'b0;
    req_val  = '0;
    req_last = '0;
    req_msg  = {32'h2222_2222, 32'h1111_1111, 32'h0000_1000};
    spi_rdy  = 1'b0;
    rsp_val  = 1'b0;
    rsp_msg  = '0;
    out_rdy  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_spi_val", 32'(spi_val), 32'd0);
    chk("rst_req_rdy", 32'(req_rdy), 32'd0);
    chk("rst_rsp_rdy", 32'(rsp_rdy), 32'd0);
    chk("rst_out_val", 32'(out_val), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
`ifdef SPI_ARB_TIMEOUT_EN
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;

    // Round robin with single-word bursts; responses drain every cycle
    @(negedge clk);
    req_val = 3'b111; req_last = 3'b111; spi_rdy = 1'b1;
    out_rdy = 3'b111; rsp_val = 1'b1; rsp_msg = 32'hC0DE_0000;
    #1;
    chk("rr_grant_cycle_spi_val", 32'(spi_val), 32'd0);
    chk("early_rsp_rdy", 32'(rsp_rdy), 32'd0);
    chk("early_out_val", 32'(out_val), 32'd0);
    @(negedge clk); #1;
    chk("rr_g0_id", 32'(grant_id), 32'd0);
    chk("rr_g0_rdy", 32'(req_rdy), 32'b001);
    chk("rr_g0_msg", spi_msg, 32'h0000_1000);
    @(negedge clk); #1;
    chk("rr_idle_spi_val", 32'(spi_val), 32'd0);
    chk("rr_rsp0_out_val", 32'(out_val), 32'b001);
    chk("rr_rsp0_out_msg", out_msg, 32'hC0DE_0000);
    @(negedge clk); #1;
    chk("rr_g1_id", 32'(grant_id), 32'd1);
    chk("rr_g1_rdy", 32'(req_rdy), 32'b010);
    chk("rr_g1_msg", spi_msg, 32'h1111_1111);
    @(negedge clk); #1;
    chk("rr_rsp1_out_val", 32'(out_val), 32'b010);
    @(negedge clk); #1;
    chk("rr_g2_id", 32'(grant_id), 32'd2);
    chk("rr_g2_rdy", 32'(req_rdy), 32'b100);
    @(negedge clk); #1;
    chk("rr_rsp2_out_val", 32'(out_val), 32'b100);
    @(negedge clk); #1;
    chk("rr_g0b_id", 32'(grant_id), 32'd0);
    chk("rr_g0b_rdy", 32'(req_rdy), 32'b001);
    @(negedge clk);
    req_val = 3'b000;
    #1;
    chk("rr_rsp0b_out_val", 32'(out_val), 32'b001);

    // Burst lock: requester 1 sends four words while 0 and 2 stay valid
    @(negedge clk);
    req_val = 3'b111; req_last = 3'b101;
    #1;
    chk("burst_grant_cycle", 32'(spi_val), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 3) req_last = 3'b111;
      #1;
      chk("burst_lock_rdy", 32'(req_rdy), 32'b010);
      if (spi_val && spi_rdy && req_rdy[1]) hs1++;
    end
    chk("burst_hs_count", 32'(hs1), 32'd4);
    @(negedge clk); #1;
    chk("burst_end_spi_val", 32'(spi_val), 32'd0);
    @(negedge clk); #1;
    chk("burst_next_id", 32'(grant_id), 32'd2);
    chk("burst_next_rdy", 32'(req_rdy), 32'b100);
    @(negedge clk);
    req_val = 3'b000;
    #1;
    chk("burst_rsp2_out_val", 32'(out_val), 32'b100);
    @(negedge clk);
    rsp_val = 1'b0;

    // Response routing: req0 then req2, responses return in order
    @(negedge clk);
    req_val = 3'b001; req_last = 3'b111;
    @(negedge clk); #1;
    chk("route_req0_rdy", 32'(req_rdy), 32'b001);
    @(negedge clk);
    req_val = 3'b100;
    @(negedge clk); #1;
    chk("route_req2_rdy", 32'(req_rdy), 32'b100);
    @(negedge clk);
    req_val = 3'b000; rsp_val = 1'b1; rsp_msg = 32'hA5A5_A5A5; out_rdy = 3'b110;
    #1;
    chk("route_bp_out_val", 32'(out_val), 32'b001);
    chk("route_bp_rsp_rdy", 32'(rsp_rdy), 32'd0);
    @(negedge clk);
    out_rdy = 3'b111;
    #1;
    chk("route_r0_out_val", 32'(out_val), 32'b001);
    chk("route_r0_out_msg", out_msg, 32'hA5A5_A5A5);
    chk("route_r0_rsp_rdy", 32'(rsp_rdy), 32'd1);
    @(negedge clk);
    rsp_msg = 32'h5A5A_5A5A;
    #1;
    chk("route_r2_out_val", 32'(out_val), 32'b100);
    chk("route_r2_out_msg", out_msg, 32'h5A5A_5A5A);
    @(negedge clk); #1;
    chk("stall_empty_rsp_rdy", 32'(rsp_rdy), 32'd0);
    chk("stall_empty_out_val", 32'(out_val), 32'd0);
    @(negedge clk);
    rsp_val = 1'b0;

    // FIFO full: four single-word bursts from req0 with no responses
    @(negedge clk);
    req_val = 3'b001; req_last = 3'b111;
    repeat (7) @(negedge clk);
    @(negedge clk); #1;
    chk("full_grant_spi_val", 32'(spi_val), 32'd0);
    @(negedge clk); #1;
    chk("full_blk_rdy", 32'(req_rdy), 32'd0);
    chk("full_blk_spi_val", 32'(spi_val), 32'd0);
    @(negedge clk);
    rsp_val = 1'b1; out_rdy = 3'b001;
    #1;
    chk("full_pop_rsp_rdy", 32'(rsp_rdy), 32'd1);
    chk("full_pop_same_cycle_rdy", 32'(req_rdy), 32'd0);
    @(negedge clk);
    rsp_val = 1'b0;
    #1;
    chk("full_after_pop_rdy", 32'(req_rdy), 32'b001);
    @(negedge clk);
    req_val = 3'b000; rsp_val = 1'b1; out_rdy = 3'b111;
    #1;
    chk("drain_rsp_rdy", 32'(rsp_rdy), 32'd1);
    repeat (3) @(negedge clk);
    @(negedge clk); #1;
    chk("drain_empty_rsp_rdy", 32'(rsp_rdy), 32'd0);

    // Reset asserted mid-burst
    @(negedge clk);
    rsp_val = 1'b0; req_val = 3'b010; req_last = 3'b000;
    @(negedge clk); #1;
    chk("mid_burst_rdy", 32'(req_rdy), 32'b010);
    @(negedge clk);
    rsp_val = 1'b1;
    #1;
    chk("pre_reset_out_val", 32'(out_val), 32'b010);
    chk("pre_reset_spi_val", 32'(spi_val), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_spi_val", 32'(spi_val), 32'd0);
    chk("async_rst_req_rdy", 32'(req_rdy), 32'd0);
    chk("async_rst_out_val", 32'(out_val), 32'd0);
    chk("async_rst_rsp_rdy", 32'(rsp_rdy), 32'd0);
    chk("async_rst_grant_id", 32'(grant_id), 32'd0);
    @(negedge clk);
    reset = 1'b1; req_val = 3'b111; req_last = 3'b111; rsp_val = 1'b0;
    #1;
    chk("post_rst_idle", 32'(spi_val), 32'd0);
    @(negedge clk); #1;
    chk("post_rst_grant_id", 32'(grant_id), 32'd0);
    chk("post_rst_rdy", 32'(req_rdy), 32'b001);
    @(negedge clk);
    req_val = 3'b000; rsp_val = 1'b1;
    @(negedge clk);
    rsp_val = 1'b0;

`ifdef SPI_ARB_TIMEOUT_EN
    // Watchdog: req0 granted, then goes silent for TMO cycles while req1 waits
    @(negedge clk);
    rsp_val = 1'b1; out_rdy = 3'b111; req_val = 3'b001; req_last = 3'b000;
    @(negedge clk); #1;
    chk("tmo_first_word_rdy", 32'(req_rdy), 32'b001);
    @(negedge clk);
    req_val = 3'b010;
    #1;
    chk("tmo_wait_err", 32'(timeout_err), 32'd0);
    chk("tmo_no_preempt", 32'(req_rdy), 32'd0);
    repeat (7) begin
      @(negedge clk); #1;
      chk("tmo_wait_err", 32'(timeout_err), 32'd0);
      chk("tmo_no_preempt", 32'(req_rdy), 32'd0);
    end
    @(negedge clk); #1;
    chk("tmo_err_set", 32'(timeout_err), 32'd1);
    chk("tmo_idle_spi_val", 32'(spi_val), 32'd0);
    @(negedge clk); #1;
    chk("tmo_next_grant_id", 32'(grant_id), 32'd1);
    chk("tmo_next_rdy", 32'(req_rdy), 32'b010);
    chk("tmo_err_sticky", 32'(timeout_err), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_master_arbiter.md
SPI_MASTER_ARBITER -- requirements
Module: spi_master_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of requesters, range 2..4.
REQ-002 SHALL have parameter DW, default 32, SPI master message width in bits.
REQ-003 SHALL have parameter IDQ, default 4, depth of the outstanding-source FIFO (power of 2).
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_val  input  NREQ  per-requester request valid.
REQ-007 SHALL have port req_last  input  NREQ  marks the final word of a requester's burst.
REQ-008 SHALL have port req_msg  input  NREQ*DW  per-requester word; requester i occupies bits [i*DW +: DW].
REQ-009 SHALL have port req_rdy  output  NREQ  per-requester accept.
REQ-010 SHALL have port spi_val / spi_rdy / spi_msg  output / input / output  1 / 1 / DW  request to the shared SPI master.
REQ-011 SHALL have port rsp_val / rsp_rdy / rsp_msg  input / output / input  1 / 1 / DW  response from the SPI master.
REQ-012 SHALL have port out_val / out_rdy / out_msg  output / input / output  NREQ / NREQ / DW  response routed back to its requester.
REQ-013 SHALL have port grant_id  output  $clog2(NREQ)  current or last grant holder, for debug.

Function
REQ-014 SHALL implement FSM IDLE/BURST. IDLE: the first req_val found searching round-robin from ptr+1 wins, moving to BURST the same cycle.
REQ-015 SHALL, in BURST, pass only the granted requester combinationally: spi_val = req_val[g] & !idq_full; req_rdy[g] = spi_rdy & !idq_full; all other req_rdy = 0.
REQ-016 SHALL, on a BURST handshake, push g into the ID FIFO. If req_last[g] is 1, it SHALL set ptr = g and return to IDLE.
REQ-017 SHALL keep the grant for the whole burst; other requesters cannot preempt a burst.
REQ-018 SHALL, in IDLE, drive spi_val = 0 and all req_rdy = 0. The first word is accepted no earlier than the cycle after the grant.
REQ-019 SHALL route responses in order. With h = FIFO head: out_val[h] = rsp_val & !idq_empty; rsp_rdy = out_rdy[h] & !idq_empty; out_msg = rsp_msg. A handshake pops the FIFO.
REQ-020 SHALL hold rsp_rdy = 0 while the FIFO is empty, so an unexpected response stalls and is not dropped.
REQ-021 SHALL block a push while the FIFO is full, even if a pop occurs in the same cycle. Push and pop in the same cycle when not full SHALL leave the count unchanged.
REQ-022 SHALL let ptr wrap modulo NREQ; with a single active requester, that requester is re-granted every burst.

Reset
REQ-023 SHALL, on reset low, asynchronously set: state = IDLE, ptr = NREQ-1 (so requester 0 has priority first), FIFO empty, grant_id = 0, every valid/rdy output = 0, and timeout state cleared.
REQ-024 SHALL, if reset asserts mid-burst, abandon the burst; outstanding IDs are discarded.

Configuration
REQ-025 SHALL gate a burst watchdog with macro SPI_ARB_TIMEOUT_EN; parameter TMO, default 64, applies only when the macro is defined.
REQ-026 SHALL, with SPI_ARB_TIMEOUT_EN defined, count BURST cycles where req_val[g] = 0. At TMO it SHALL force IDLE, set ptr = g, and set sticky output timeout_err (1 bit, cleared only by reset). Any handshake clears the count.
REQ-027 SHALL, without SPI_ARB_TIMEOUT_EN, have no timeout_err port and no counter; bursts end only on req_last.

Structure
REQ-028 SHALL put the state enum (IDLE, BURST) and the ID-width function in shared package spi_arb_pkg.
REQ-029 SHALL implement the ID FIFO as sub-module spi_arb_id_fifo: parameterised width/depth, push/pop/full/empty, same reset.

Verification
REQ-030 SHALL cover round-robin: all three requesters request single-word bursts continuously -> grants 0,1,2,0,1,2; grant_id follows.
REQ-031 SHALL cover burst lock: req1 sends a 4-word burst (last on word 4) while req0 and req2 stay valid -> exactly 4 spi handshakes from req1, then grant goes to 2.
REQ-032 SHALL cover response routing: req0 then req2 each send one word, SPI responses 0xA5A5A5A5 then 0x5A5A5A5A -> out_val[0] carries 0xA5A5A5A5, then out_val[2] carries 0x5A5A5A5A.
REQ-033 SHALL cover FIFO full: rsp_val held 0 while 4 words are accepted -> the 5th request sees req_rdy = 0 until the first response pops; an early rsp_val with an empty FIFO -> rsp_rdy = 0.
REQ-034 SHALL cover reset: reset asserted mid-burst -> all outputs 0 asynchronously; after release, req0 is granted first.
REQ-035 SHALL cover the watchdog (SPI_ARB_TIMEOUT_EN, TMO = 8): granted requester drops val for 8 cycles -> timeout_err = 1 and the next requester is granted.
